// File: rtl/alu_decode_pipe.sv
// alu_decode_pipe: ID-stage RV32I ALU control decoder feeding a registered ID/EX stage
// with valid/stall/flush and a saturating illegal-encoding counter. RV32M decode: RISCV_MULDIV_EN.
module alu_decode_pipe #(
  parameter int CTRL_W = 5,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic [1:0]        alu_op,
  input  logic [2:0]        funct3,
  input  logic              funct75,
  input  logic              funct70,
  input  logic              op5,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_alu_ctrl,
  output logic [1:0]        ex_data_type,
  output logic              ex_mem_unsigned,
  output logic              ex_illegal,
  output logic [CNT_W-1:0]  illegal_cnt
);

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_AND  = 5'd2;
  localparam logic [4:0] ALU_OR   = 5'd3;
  localparam logic [4:0] ALU_SLL  = 5'd4;
  localparam logic [4:0] ALU_SLT  = 5'd5;
  localparam logic [4:0] ALU_SRL  = 5'd6;
  localparam logic [4:0] ALU_SRA  = 5'd7;
  localparam logic [4:0] ALU_SLTU = 5'd8;
  localparam logic [4:0] ALU_XOR  = 5'd9;

  localparam logic [1:0] DT_WORD = 2'b00;
  localparam logic [1:0] DT_BYTE = 2'b01;
  localparam logic [1:0] DT_HALF = 2'b10;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [4:0]        w_code;
  logic [1:0]        w_dt;
  logic              w_uns;
  logic              w_illegal;
  logic              w_muldiv_enc;
  logic              w_accept;
  logic [CTRL_W-1:0] w_ctrl_fin;
  logic [1:0]        w_dt_fin;
  logic              w_uns_fin;

  logic              r_valid;
  logic [CTRL_W-1:0] r_ctrl;
  logic [1:0]        r_dt;
  logic              r_uns;
  logic              r_illegal;
  logic [CNT_W-1:0]  r_cnt;

  // R-type with funct7 = 0000001 selects the RV32M group
  assign w_muldiv_enc = op5 & funct70 & ~funct75;
  assign w_accept     = id_valid & ~stall & ~flush;

  // Raw decode of the ID-stage fields into ALU code, data type, signedness and legality
  always_comb begin
    w_code    = ALU_ADD;
    w_dt      = DT_WORD;
    w_uns     = 1'b0;
    w_illegal = 1'b0;
    case (alu_op)
      2'b00: begin
        w_uns = funct3[2];
        case (funct3[1:0])
          2'b00:   w_dt = DT_BYTE;
          2'b01:   w_dt = DT_HALF;
          2'b10:   w_dt = DT_WORD;
          default: w_dt = DT_WORD;
        endcase
        // Stores have no unsigned forms; LWU does not exist in RV32
        w_illegal = (funct3[1:0] == 2'b11) || (funct3[2] && op5) || (funct3 == 3'b110);
      end
      2'b01: begin
        case (funct3)
          3'b000, 3'b001: w_code = ALU_SUB;
          3'b100, 3'b101: w_code = ALU_SLT;
          3'b110, 3'b111: w_code = ALU_SLTU;
          default:        w_illegal = 1'b1;
        endcase
      end
      2'b10: begin
        if (w_muldiv_enc) begin
`ifdef RISCV_MULDIV_EN
          w_code = {2'b10, funct3};
`else
          w_illegal = 1'b1;
`endif
        end else begin
          case (funct3)
            3'b000:  w_code = (op5 && funct75) ? ALU_SUB : ALU_ADD;
            3'b001:  w_code = ALU_SLL;
            3'b010:  w_code = ALU_SLT;
            3'b011:  w_code = ALU_SLTU;
            3'b100:  w_code = ALU_XOR;
            3'b101:  w_code = funct75 ? ALU_SRA : ALU_SRL;
            3'b110:  w_code = ALU_OR;
            3'b111:  w_code = ALU_AND;
            default: w_code = ALU_ADD;
          endcase
          w_illegal = (!op5 && (funct3 == 3'b001) && funct75) ||
                      (op5 && funct75 && (funct3 != 3'b000) && (funct3 != 3'b101));
        end
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // An illegal decode collapses to a harmless ADD with no memory attributes
  assign w_ctrl_fin = w_illegal ? {CTRL_W{1'b0}} : CTRL_W'(w_code);
  assign w_dt_fin   = w_illegal ? DT_WORD : w_dt;
  assign w_uns_fin  = w_illegal ? 1'b0 : w_uns;

  // ID/EX register: flush beats stall beats a normal load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_ctrl    <= {CTRL_W{1'b0}};
      r_dt      <= 2'b00;
      r_uns     <= 1'b0;
      r_illegal <= 1'b0;
    end else if (flush) begin
      r_valid   <= 1'b0;
      r_ctrl    <= {CTRL_W{1'b0}};
      r_dt      <= 2'b00;
      r_uns     <= 1'b0;
      r_illegal <= 1'b0;
    end else if (stall) begin
      r_valid   <= r_valid;
      r_ctrl    <= r_ctrl;
      r_dt      <= r_dt;
      r_uns     <= r_uns;
      r_illegal <= r_illegal;
    end else if (id_valid) begin
      r_valid   <= 1'b1;
      r_ctrl    <= w_ctrl_fin;
      r_dt      <= w_dt_fin;
      r_uns     <= w_uns_fin;
      r_illegal <= w_illegal;
    end else begin
      r_valid   <= 1'b0;
      r_ctrl    <= {CTRL_W{1'b0}};
      r_dt      <= 2'b00;
      r_uns     <= 1'b0;
      r_illegal <= 1'b0;
    end
  end

  // Saturating count of illegal decodes actually accepted into EX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (w_accept && w_illegal && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_ONE;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign ex_valid        = r_valid;
  assign ex_alu_ctrl     = r_ctrl;
  assign ex_data_type    = r_dt;
  assign ex_mem_unsigned = r_uns;
  assign ex_illegal      = r_illegal;
  assign illegal_cnt     = r_cnt;

endmodule

// File: tb/tb_alu_decode_pipe.sv
// Self-checking bench for alu_decode_pipe: directed vector table plus stall/flush,
// saturation (second instance with CNT_W = 2) and asynchronous reset sequences.
module tb_alu_decode_pipe;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic       stall;
  logic       flush;
  logic [1:0] alu_op;
  logic [2:0] funct3;
  logic       funct75;
  logic       funct70;
  logic       op5;

  logic       ex_valid;
  logic [4:0] ex_alu_ctrl;
  logic [1:0] ex_data_type;
  logic       ex_mem_unsigned;
  logic       ex_illegal;
  logic [7:0] illegal_cnt;

  logic       s_ex_valid;
  logic [4:0] s_ex_alu_ctrl;
  logic [1:0] s_ex_data_type;
  logic       s_ex_mem_unsigned;
  logic       s_ex_illegal;
  logic [1:0] s_illegal_cnt;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;

  typedef struct {
    logic [1:0] alu_op;
    logic [2:0] f3;
    logic       f75;
    logic       f70;
    logic       op5;
    logic [4:0] ctrl;
    logic [1:0] dt;
    logic       uns;
    logic       ill;
  } vec_t;

  vec_t vecs[$];

  alu_decode_pipe #(.CTRL_W(5), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .stall(stall), .flush(flush),
    .alu_op(alu_op), .funct3(funct3), .funct75(funct75), .funct70(funct70), .op5(op5),
    .ex_valid(ex_valid), .ex_alu_ctrl(ex_alu_ctrl), .ex_data_type(ex_data_type),
    .ex_mem_unsigned(ex_mem_unsigned), .ex_illegal(ex_illegal), .illegal_cnt(illegal_cnt)
  );

  alu_decode_pipe #(.CTRL_W(5), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .stall(stall), .flush(flush),
    .alu_op(alu_op), .funct3(funct3), .funct75(funct75), .funct70(funct70), .op5(op5),
    .ex_valid(s_ex_valid), .ex_alu_ctrl(s_ex_alu_ctrl), .ex_data_type(s_ex_data_type),
    .ex_mem_unsigned(s_ex_mem_unsigned), .ex_illegal(s_ex_illegal), .illegal_cnt(s_illegal_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_ex(input string nm, input int v, input int c, input int d, input int u, input int il);
    chk({nm, ".valid"}, int'(ex_valid), v);
    chk({nm, ".ctrl"}, int'(ex_alu_ctrl), c);
    chk({nm, ".dtype"}, int'(ex_data_type), d);
    chk({nm, ".uns"}, int'(ex_mem_unsigned), u);
    chk({nm, ".illegal"}, int'(ex_illegal), il);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic f75,
                       input logic f70, input logic o5);
    alu_op  = op;
    funct3  = f3;
    funct75 = f75;
    funct70 = f70;
    op5     = o5;
  endtask

  task automatic addv(input logic [1:0] op, input logic [2:0] f3, input logic f75, input logic f70,
                      input logic o5, input logic [4:0] c, input logic [1:0] d, input logic u,
                      input logic il);
    vec_t v;
    v.alu_op = op; v.f3 = f3; v.f75 = f75; v.f70 = f70; v.op5 = o5;
    v.ctrl = c; v.dt = d; v.uns = u; v.ill = il;
    vecs.push_back(v);
  endtask

  initial begin
    int sat_exp[5];
    logic [4:0] frz_ctrl;

    // alu_op, funct3, funct75, funct70, op5 -> ctrl, dtype, unsigned, illegal
    addv(2'b10, 3'b101, 1'b1, 1'b0, 1'b1, 5'd7, 2'b00, 1'b0, 1'b0); // SRA
    addv(2'b10, 3'b101, 1'b0, 1'b0, 1'b1, 5'd6, 2'b00, 1'b0, 1'b0); // SRL
    addv(2'b10, 3'b000, 1'b1, 1'b0, 1'b0, 5'd0, 2'b00, 1'b0, 1'b0); // ADDI, not SUB
    addv(2'b10, 3'b000, 1'b1, 1'b0, 1'b1, 5'd1, 2'b00, 1'b0, 1'b0); // SUB
    addv(2'b10, 3'b011, 1'b0, 1'b0, 1'b1, 5'd8, 2'b00, 1'b0, 1'b0); // SLTU
    addv(2'b10, 3'b100, 1'b0, 1'b0, 1'b0, 5'd9, 2'b00, 1'b0, 1'b0); // XORI
    addv(2'b10, 3'b110, 1'b0, 1'b0, 1'b1, 5'd3, 2'b00, 1'b0, 1'b0); // OR
    addv(2'b10, 3'b111, 1'b0, 1'b0, 1'b0, 5'd2, 2'b00, 1'b0, 1'b0); // ANDI
    addv(2'b10, 3'b001, 1'b0, 1'b0, 1'b0, 5'd4, 2'b00, 1'b0, 1'b0); // SLLI
    addv(2'b10, 3'b010, 1'b0, 1'b0, 1'b1, 5'd5, 2'b00, 1'b0, 1'b0); // SLT
    addv(2'b10, 3'b101, 1'b1, 1'b0, 1'b0, 5'd7, 2'b00, 1'b0, 1'b0); // SRAI
    addv(2'b10, 3'b001, 1'b1, 1'b0, 1'b0, 5'd0, 2'b00, 1'b0, 1'b1); // bad SLLI
    addv(2'b10, 3'b111, 1'b1, 1'b0, 1'b1, 5'd0, 2'b00, 1'b0, 1'b1); // bad R-type
    addv(2'b00, 3'b100, 1'b0, 1'b0, 1'b0, 5'd0, 2'b01, 1'b1, 1'b0); // LBU
    addv(2'b00, 3'b010, 1'b0, 1'b0, 1'b1, 5'd0, 2'b00, 1'b0, 1'b0); // SW
    addv(2'b00, 3'b101, 1'b0, 1'b0, 1'b0, 5'd0, 2'b10, 1'b1, 1'b0); // LHU
    addv(2'b00, 3'b001, 1'b0, 1'b0, 1'b1, 5'd0, 2'b10, 1'b0, 1'b0); // SH
    addv(2'b00, 3'b100, 1'b0, 1'b0, 1'b1, 5'd0, 2'b00, 1'b0, 1'b1); // unsigned store
    addv(2'b00, 3'b110, 1'b0, 1'b0, 1'b0, 5'd0, 2'b00, 1'b0, 1'b1); // LWU
    addv(2'b00, 3'b011, 1'b0, 1'b0, 1'b0, 5'd0, 2'b00, 1'b0, 1'b1); // LD
    addv(2'b01, 3'b110, 1'b0, 1'b0, 1'b1, 5'd8, 2'b00, 1'b0, 1'b0); // BLTU
    addv(2'b01, 3'b010, 1'b0, 1'b0, 1'b1, 5'd0, 2'b00, 1'b0, 1'b1); // bad branch
    addv(2'b01, 3'b001, 1'b0, 1'b0, 1'b1, 5'd1, 2'b00, 1'b0, 1'b0); // BNE
    addv(2'b01, 3'b101, 1'b0, 1'b0, 1'b1, 5'd5, 2'b00, 1'b0, 1'b0); // BGE
    addv(2'b11, 3'b000, 1'b0, 1'b0, 1'b1, 5'd0, 2'b00, 1'b0, 1'b1); // reserved class
    addv(2'b10, 3'b000, 1'b0, 1'b1, 1'b0, 5'd0, 2'b00, 1'b0, 1'b0); // ADDI, funct70 ignored
`ifdef RISCV_MULDIV_EN
    addv(2'b10, 3'b111, 1'b0, 1'b1, 1'b1, 5'd23, 2'b00, 1'b0, 1'b0); // REMU
    addv(2'b10, 3'b000, 1'b0, 1'b1, 1'b1, 5'd16, 2'b00, 1'b0, 1'b0); // MUL
`else
    addv(2'b10, 3'b111, 1'b0, 1'b1, 1'b1, 5'd0, 2'b00, 1'b0, 1'b1); // REMU unsupported
    addv(2'b10, 3'b000, 1'b0, 1'b1, 1'b1, 5'd0, 2'b00, 1'b0, 1'b1); // MUL unsupported
`endif
    sat_exp = '{1, 2, 3, 3, 3};

    rst_n = 1'b0; id_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    drive(2'b00, 3'b000, 1'b0, 1'b0, 1'b0);
    step(); step();
    chk_ex("reset", 0, 0, 0, 0, 0);
    chk("reset.cnt", int'(illegal_cnt), 0);
    chk("reset.sat_cnt", int'(s_illegal_cnt), 0);
    rst_n = 1'b1;

    // Saturation: five accepted illegal ops
    id_valid = 1'b1;
    drive(2'b11, 3'b000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      exp_cnt++;
      chk($sformatf("sat%0d.cnt2", i), int'(s_illegal_cnt), sat_exp[i]);
      chk($sformatf("sat%0d.cnt8", i), int'(illegal_cnt), exp_cnt);
      chk($sformatf("sat%0d.illegal", i), int'(ex_illegal), 1);
    end

    // Vector table: one decode per cycle, 1-cycle latency
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].alu_op, vecs[i].f3, vecs[i].f75, vecs[i].f70, vecs[i].op5);
      step();
      if (vecs[i].ill && exp_cnt < 255) exp_cnt++;
      chk_ex($sformatf("v%0d", i), 1, int'(vecs[i].ctrl), int'(vecs[i].dt),
             int'(vecs[i].uns), int'(vecs[i].ill));
      chk($sformatf("v%0d.cnt", i), int'(illegal_cnt), exp_cnt);
    end

    // Bubble: illegal fields but id_valid low must neither load nor count
    id_valid = 1'b0;
    drive(2'b11, 3'b000, 1'b0, 1'b0, 1'b0);
    step();
    chk_ex("bubble", 0, 0, 0, 0, 0);
    chk("bubble.cnt", int'(illegal_cnt), exp_cnt);

    // Load an illegal branch, then stall 3 cycles with other inputs driven
    id_valid = 1'b1;
    drive(2'b01, 3'b010, 1'b0, 1'b0, 1'b1);
    step();
    exp_cnt++;
    chk_ex("pre_stall", 1, 0, 0, 0, 1);
    chk("pre_stall.cnt", int'(illegal_cnt), exp_cnt);
    stall = 1'b1;
    drive(2'b11, 3'b000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_ex($sformatf("stall%0d", i), 1, 0, 0, 0, 1);
      chk($sformatf("stall%0d.cnt", i), int'(illegal_cnt), exp_cnt);
    end

    // Legal load under stall, then released: it lands on the release edge
    drive(2'b00, 3'b101, 1'b0, 1'b0, 1'b0);
    step();
    chk_ex("stall3", 1, 0, 0, 0, 1);
    stall = 1'b0;
    step();
    chk_ex("release", 1, 0, 2, 1, 0);
    frz_ctrl = ex_alu_ctrl;

    // Flush and stall together with an illegal op presented: flush wins, no count
    stall = 1'b1; flush = 1'b1;
    drive(2'b11, 3'b000, 1'b0, 1'b0, 1'b0);
    step();
    chk_ex("flush_stall", 0, 0, 0, 0, 0);
    chk("flush_stall.cnt", int'(illegal_cnt), exp_cnt);
    stall = 1'b0; flush = 1'b0;

    // Asynchronous reset mid-stream with an illegal op in flight
    step();
    exp_cnt++;
    chk_ex("inflight", 1, 0, 0, 0, 1);
    chk("inflight.cnt", int'(illegal_cnt), exp_cnt);
    #2;
    rst_n = 1'b0;
    #1;
    chk_ex("async_rst", 0, 0, 0, 0, 0);
    chk("async_rst.cnt", int'(illegal_cnt), 0);
    chk("async_rst.sat_cnt", int'(s_illegal_cnt), 0);
    step();
    drive(2'b10, 3'b101, 1'b1, 1'b0, 1'b1);
    rst_n = 1'b1;
    step();
    chk_ex("post_rst", 1, 7, 0, 0, 0);
    chk("post_rst.cnt", int'(illegal_cnt), 0);
    chk("frz_ctrl", int'(frz_ctrl), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
